// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port between NUM_REQ writeback requesters.
// Optional macro RF_WB_BYPASS_EN adds read-port forwarding of the pending registered write.
module rf_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [5*NUM_REQ-1:0]    req_addr,
    input  logic [32*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    wb_we,
    output logic [4:0]              wb_addr,
    output logic [31:0]             wb_data,
    output logic [CNT_W-1:0]        conflict_cnt
`ifdef RF_WB_BYPASS_EN
    ,
    input  logic [4:0]              rd_a1,
    input  logic [4:0]              rd_a2,
    input  logic [31:0]             rf_rd1,
    input  logic [31:0]             rf_rd2,
    output logic [31:0]             fwd_rd1,
    output logic [31:0]             fwd_rd2
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              wb_we_q, wb_we_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [4:0]        addr_arr [NUM_REQ];
    logic [31:0]       data_arr [NUM_REQ];

    logic              found;
    logic [PTR_W-1:0]  gidx;
    logic [PTR_W:0]    cand;
    logic              seen_valid;
    logic              multi_valid;
    logic              accept;
    logic [4:0]        sel_addr;
    logic [31:0]       sel_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[5*gi +: 5];
            assign data_arr[gi] = req_data[32*gi +: 32];
        end
    endgenerate

    // Rotating priority search: start at the pointer, wrap modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && req_valid[cand[PTR_W-1:0]]) begin
                found = 1'b1;
                gidx  = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        seen_valid  = 1'b0;
        multi_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                if (seen_valid) begin
                    multi_valid = 1'b1;
                end
                seen_valid = 1'b1;
            end
        end
    end

    // No grant is ever issued while reset is held.
    always_comb begin
        req_ready = '0;
        if (found && !rst) begin
            req_ready[gidx] = 1'b1;
        end
    end

    assign accept   = found && !rst;
    assign sel_addr = addr_arr[gidx];
    assign sel_data = data_arr[gidx];

    always_comb begin
        ptr_d     = ptr_q;
        wb_we_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        cnt_d     = cnt_q;
        if (accept) begin
            if (gidx == PTR_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gidx + 1'b1;
            end
            wb_we_d   = (sel_addr != 5'd0);
            wb_addr_d = sel_addr;
            wb_data_d = sel_data;
        end
        if (multi_valid && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= 5'd0;
            wb_data_q <= 32'd0;
            cnt_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wb_we        = wb_we_q;
    assign wb_addr      = wb_addr_q;
    assign wb_data      = wb_data_q;
    assign conflict_cnt = cnt_q;

`ifdef RF_WB_BYPASS_EN
    // Readers see the registered write one cycle before the register file holds it.
    assign fwd_rd1 = (wb_we_q && (wb_addr_q == rd_a1) && (rd_a1 != 5'd0)) ? wb_data_q : rf_rd1;
    assign fwd_rd2 = (wb_we_q && (wb_addr_q == rd_a2) && (rd_a2 != 5'd0)) ? wb_data_q : rf_rd2;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: handshake, round-robin order, x0 writes, reset, counter saturation.
module tb_rf_wb_arbiter;

    localparam int NUM_REQ = 2;
    localparam int CNT_W   = 4;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [5*NUM_REQ-1:0]  req_addr;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  wb_we;
    logic [4:0]            wb_addr;
    logic [31:0]           wb_data;
    logic [CNT_W-1:0]      conflict_cnt;
`ifdef RF_WB_BYPASS_EN
    logic [4:0]            rd_a1, rd_a2;
    logic [31:0]           rf_rd1, rf_rd2, fwd_rd1, fwd_rd2;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Register file model; it shares the arbiter's reset, so nothing commits during reset.
    logic [31:0] rf_m [32] = '{default: 32'd0};

    rf_wb_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .conflict_cnt (conflict_cnt)
`ifdef RF_WB_BYPASS_EN
        ,
        .rd_a1        (rd_a1),
        .rd_a2        (rd_a2),
        .rf_rd1       (rf_rd1),
        .rf_rd2       (rf_rd2),
        .fwd_rd1      (fwd_rd1),
        .fwd_rd2      (fwd_rd2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && wb_we && wb_addr != 5'd0) begin
            rf_m[wb_addr] <= wb_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        rst       = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[5*i +: 5]   = a;
        req_data[32*i +: 32] = d;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b01;
        req_addr  = '0;
        req_data  = '0;
`ifdef RF_WB_BYPASS_EN
        rd_a1 = 5'd0; rd_a2 = 5'd0; rf_rd1 = 32'd0; rf_rd2 = 32'd0;
`endif
        #2;
        check("ready_in_reset", 32'(req_ready), 32'd0);
        tick();
        check("rst_wb_we", 32'(wb_we), 32'd0);
        check("rst_wb_addr", 32'(wb_addr), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_cnt", 32'(conflict_cnt), 32'd0);
        rst       = 1'b0;
        req_valid = '0;
        tick();

        // Single requester
        set_req(0, 5'd5, 32'h0000_00AA);
        req_valid = 2'b01;
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("single_we", 32'(wb_we), 32'd1);
        check("single_addr", 32'(wb_addr), 32'd5);
        check("single_data", wb_data, 32'hAA);
        tick();
        check("single_rf5", rf_m[5], 32'hAA);
        check("single_we_drop", 32'(wb_we), 32'd0);

        // Contention fairness: each requester drops valid after its grant
        do_reset();
        set_req(0, 5'd6, 32'd1);
        set_req(1, 5'd9, 32'd2);
        req_valid = 2'b11;
        #1;
        check("fair_ready0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b10;
        #1;
        check("fair_ready1", 32'(req_ready), 32'h2);
        check("fair_wb_addr0", 32'(wb_addr), 32'd6);
        tick();
        req_valid = '0;
        check("fair_wb_addr1", 32'(wb_addr), 32'd9);
        check("fair_wb_data1", wb_data, 32'd2);
        tick();
        check("fair_cnt", 32'(conflict_cnt), 32'd1);
        check("fair_rf6", rf_m[6], 32'd1);
        check("fair_rf9", rf_m[9], 32'd2);

        // Sustained contention for 10 cycles
        do_reset();
        set_req(0, 5'd3, 32'h30);
        set_req(1, 5'd4, 32'h40);
        req_valid = 2'b11;
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("sus_ready_%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k > 0) begin
                check($sformatf("sus_we_%0d", k), 32'(wb_we), 32'd1);
                check($sformatf("sus_addr_%0d", k), 32'(wb_addr), (k % 2 == 1) ? 32'd3 : 32'd4);
            end
            tick();
        end
        req_valid = '0;
        check("sus_cnt", 32'(conflict_cnt), 32'd10);
        check("sus_last_addr", 32'(wb_addr), 32'd4);
        check("sus_last_data", wb_data, 32'h40);
        tick();
        check("sus_we_end", 32'(wb_we), 32'd0);

        // x0 write accepted without write enable; pointer still advances
        set_req(0, 5'd0, 32'hFFFF_FFFF);
        req_valid = 2'b01;
        #1;
        check("x0_ready", 32'(req_ready), 32'h1);
        tick();
        check("x0_we", 32'(wb_we), 32'd0);
        set_req(1, 5'd2, 32'h22);
        req_valid = 2'b11;
        #1;
        check("x0_ptr_adv", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        check("x0_rf0", rf_m[0], 32'd0);
        check("x0_rf2", rf_m[2], 32'h22);

        // Reset one cycle after an accepted grant
        set_req(0, 5'd8, 32'h88);
        req_valid = 2'b01;
        #1;
        check("rmid_ready", 32'(req_ready), 32'h1);
        tick();
        check("rmid_pending", 32'(wb_we), 32'd1);
        rst       = 1'b1;
        req_valid = 2'b11;
        #1;
        check("rmid_ready_rst", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;
        check("rmid_we", 32'(wb_we), 32'd0);
        check("rmid_cnt", 32'(conflict_cnt), 32'd0);
        check("rmid_rf8", rf_m[8], 32'd0);
        #1;
        check("rmid_ptr0", 32'(req_ready), 32'h1);
        req_valid = '0;
        tick();

        // Counter saturation
        do_reset();
        req_valid = 2'b11;
        repeat (20) tick();
        req_valid = '0;
        check("sat_cnt", 32'(conflict_cnt), 32'd15);
        tick();
        check("sat_hold", 32'(conflict_cnt), 32'd15);

`ifdef RF_WB_BYPASS_EN
        set_req(0, 5'd6, 32'h1234);
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        rd_a1 = 5'd6; rf_rd1 = 32'd20;
        rd_a2 = 5'd7; rf_rd2 = 32'd33;
        #1;
        check("byp_fwd1_hit", fwd_rd1, 32'h1234);
        check("byp_fwd2_miss", fwd_rd2, 32'd33);
        rd_a1 = 5'd0;
        #1;
        check("byp_fwd1_x0", fwd_rd1, 32'd20);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
